// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
//   muldiv_op_t    : operation encoding presented on the request port
//   muldiv_state_t : sequencer FSM states
//   MULDIV_ITER    : default operand width, which is also the iteration count
package muldiv_pkg;

    localparam int MULDIV_ITER = 32;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        RUN,
        FIXUP,
        DONE
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the main control FSM and the mul/div sequencer.
//   start, op, opa, opb          : request, sampled while the sequencer is IDLE or DONE
//   busy, done, hi, lo, div_zero : status and HI/LO results
// master = control FSM side, slave = sequencer side.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_ITER
);
    logic             start;
    muldiv_op_t       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, op, opa, opb,
        input  busy, done, hi, lo, div_zero
    );

    modport slave (
        input  start, op, opa, opb,
        output busy, done, hi, lo, div_zero
    );
endinterface

// File: rtl/muldiv_datapath.sv
// Datapath for the mul/div sequencer: operand magnitudes, the {acc,q} shift
// pair (product high/low or remainder/quotient), the shared adder/subtractor,
// the final sign fixup and the HI/LO result registers.
//   Clk, reset         : clock, synchronous active-high reset
//   init               : load sign flags and magnitudes from opa/opb
//   step               : one shift-add (multiply) or restoring-divide iteration
//   fix                : load sign-corrected results into hi/lo
//   is_div, is_signed  : operation class, stable for the whole operation
//   opa, opb           : latched operands
//   hi, lo             : result registers
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_ITER
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             init,
    input  logic             step,
    input  logic             fix,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic             sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] acc;   // product high half / partial remainder
    logic [WIDTH-1:0] q;     // multiplier bits / dividend-quotient bits

    logic             sa_n, sb_n;
    logic [WIDTH-1:0] mag_a_n, mag_b_n;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH+1:0] diff;
    logic             borrow;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] hi_n, lo_n;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        sa_n    = is_signed & opa[WIDTH-1];
        sb_n    = is_signed & opb[WIDTH-1];
        // |0x80..0| wraps back to 0x80..0, which is the correct unsigned magnitude.
        mag_a_n = sa_n ? -opa : opa;
        mag_b_n = sb_n ? -opb : opb;

        // Multiply: 33-bit add so the carry shifts into the product.
        sum     = {1'b0, acc} + {1'b0, (q[0] ? mag_a : {WIDTH{1'b0}})};

        // Divide: the shifted remainder needs one extra bit, the trial
        // subtract one more to expose the borrow.
        r_sh    = {acc, q[WIDTH-1]};
        diff    = {1'b0, r_sh} - {2'b00, mag_b};
        borrow  = diff[WIDTH+1];

        prod     = {acc, q};
        prod_fix = (sa ^ sb) ? -prod : prod;

        hi_n = prod_fix[2*WIDTH-1:WIDTH];
        lo_n = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (mag_b == '0) begin
                // Divide by zero: hand back the original dividend, all-ones quotient.
                hi_n = sa ? -mag_a : mag_a;
                lo_n = '1;
            end else begin
                hi_n = sa ? -acc : acc;
                lo_n = (sa ^ sb) ? -q : q;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge Clk) begin
        if (reset) begin
            sa    <= 1'b0;
            sb    <= 1'b0;
            mag_a <= '0;
            mag_b <= '0;
            acc   <= '0;
            q     <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (init) begin
                sa    <= sa_n;
                sb    <= sb_n;
                mag_a <= mag_a_n;
                mag_b <= mag_b_n;
                acc   <= '0;
                q     <= is_div ? mag_a_n : mag_b_n;
            end else if (step) begin
                if (is_div) begin
                    acc <= borrow ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], ~borrow};
                end else begin
                    acc <= sum[WIDTH:1];
                    q   <= {sum[0], q[WIDTH-1:1]};
                end
            end
            if (fix) begin
                hi <= hi_n;
                lo <= lo_n;
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer for the multicycle MIPS core. Accepts one
// MULT/MULTU/DIV/DIVU request, runs WIDTH shift-add or restoring-divide
// iterations on operand magnitudes, sign-corrects, and loads HI/LO.
//   Clk   : system clock, rising edge
//   reset : synchronous active-high; aborts any operation, clears all state
//   bus   : request (start/op/opa/opb) and status/results
//           (busy/done/hi/lo/div_zero)
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_ITER
) (
    input  logic     Clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    muldiv_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    muldiv_op_t       op_q;
    logic [WIDTH-1:0] opa_q, opb_q;
    logic             div_zero_q;

    logic accept, is_div, is_signed, b_zero;
    logic busy, done, init, step, fix;

    assign accept    = bus.start && ((state_q == IDLE) || (state_q == DONE));
    assign is_div    = (op_q == DIV) || (op_q == DIVU);
    assign is_signed = (op_q == MULT) || (op_q == DIV);
    assign b_zero    = is_div && (opb_q == '0);

    always_ff @(posedge Clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        init    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = PREP;
            end
            PREP: begin
                busy    = 1'b1;
                init    = 1'b1;
                state_d = b_zero ? FIXUP : RUN;
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIXUP;
            end
            FIXUP: begin
                busy    = 1'b1;
                fix     = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = bus.start ? PREP : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            cnt_q      <= '0;
            op_q       <= MULT;
            opa_q      <= '0;
            opb_q      <= '0;
            div_zero_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q       <= bus.op;
                opa_q      <= bus.opa;
                opb_q      <= bus.opb;
                div_zero_q <= 1'b0;
            end else if (fix && b_zero) begin
                div_zero_q <= 1'b1;
            end
            if (init)      cnt_q <= '0;
            else if (step) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .Clk       (Clk),
        .reset     (reset),
        .init      (init),
        .step      (step),
        .fix       (fix),
        .is_div    (is_div),
        .is_signed (is_signed),
        .opa       (opa_q),
        .opb       (opb_q),
        .hi        (bus.hi),
        .lo        (bus.lo)
    );

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.div_zero = div_zero_q;

endmodule
